// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared widths, halt opcode, reset PC and FSM state encodings for the
//   instruction-fetch stage and its helpers.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int ISIZE = 16;   // PC / instruction-memory address width (word addressed)
    localparam int DSIZE = 32;   // instruction width
    localparam int OPC_W = 4;    // opcode field width, top bits of the instruction

    localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;
    localparam logic [ISIZE-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sat_counter.sv
// -----------------------------------------------------------------------------
// fetch_sat_counter
//   Saturating event counter: counts up by one on each cycle with inc=1 and
//   sticks at all-ones instead of wrapping.
//
//   Ports:
//     clk  in   clock
//     rst  in   synchronous active-high reset, clears the count
//     inc  in   count enable
//     cnt  out  W-bit registered count
// -----------------------------------------------------------------------------
module fetch_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Drives the instruction-memory address every
//   cycle, absorbs the memory's one-cycle registered-address read latency and
//   presents a registered IF/ID bundle to decode. Handles decode stall,
//   execute-stage redirect and a halt opcode.
//
//   Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_cnt / stall_cnt).
//
//   Ports:
//     clk          in   clock
//     rst          in   synchronous active-high reset
//     stall        in   decode cannot accept; hold IF/ID and the fetch address
//     redirect     in   execute-stage control transfer taken this cycle
//     redirect_pc  in   redirect target
//     imem_addr    out  instruction-memory address (combinational)
//     imem_rdata   in   memory data for the address of the previous cycle
//     if_pc        out  IF/ID PC
//     if_instr     out  IF/ID instruction
//     if_valid     out  IF/ID entry holds a real instruction
//     halted       out  fetch is in HALT
//     fetch_cnt    out  (FETCH_PERF_CNT_EN) valid instructions delivered
//     stall_cnt    out  (FETCH_PERF_CNT_EN) stalled RUN cycles
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [DSIZE-1:0] imem_rdata,
    output logic [ISIZE-1:0] if_pc,
    output logic [DSIZE-1:0] if_instr,
    output logic             if_valid,
    output logic             halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    fetch_state_t     state;
    logic [ISIZE-1:0] req_pc;     // address whose data is on imem_rdata now
    logic             req_valid;  // that data is on the correct path

    logic [ISIZE-1:0] req_pc_inc;
    logic             is_halt_opc;

    // Natural ISIZE-bit wrap: 16'hFFFF -> 16'h0000.
    assign req_pc_inc  = req_pc + ISIZE'(1);
    assign is_halt_opc = (imem_rdata[DSIZE-1 -: OPC_W] == HALT_OPC);
    assign halted      = (state == FS_HALT);

    // Address selection. On a stall the memory re-reads req_pc so the word
    // on imem_rdata is still the one IF/ID will take when the stall lifts.
    always_comb begin
        imem_addr = RESET_PC;
        if (!rst) begin
            case (state)
                FS_BOOT: imem_addr = RESET_PC;
                FS_RUN: begin
                    if (redirect)   imem_addr = redirect_pc;
                    else if (stall) imem_addr = req_pc;
                    else            imem_addr = req_pc_inc;
                end
                FS_HALT: imem_addr = redirect ? redirect_pc : req_pc;
                default: imem_addr = RESET_PC;
            endcase
        end
    end

    // FSM, fetch request and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FS_BOOT;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
            if_valid  <= 1'b0;
        end else begin
            case (state)
                FS_BOOT: begin
                    req_pc    <= RESET_PC;
                    req_valid <= 1'b1;
                    state     <= FS_RUN;
                end
                FS_RUN: begin
                    if (redirect) begin
                        // Squash the word in flight and the IF/ID slot.
                        req_pc    <= redirect_pc;
                        req_valid <= 1'b1;
                        if_valid  <= 1'b0;
                    end else if (!stall) begin
                        if_instr  <= imem_rdata;
                        if_pc     <= req_pc;
                        if_valid  <= req_valid;
                        req_pc    <= req_pc_inc;
                        req_valid <= 1'b1;
                        if (req_valid && is_halt_opc) begin
                            // Halt word still goes to decode; nothing after it does.
                            state     <= FS_HALT;
                            req_valid <= 1'b0;
                        end
                    end
                end
                FS_HALT: begin
                    if (redirect) begin
                        // A halt fetched down a wrong path is undone here.
                        req_pc    <= redirect_pc;
                        req_valid <= 1'b1;
                        if_valid  <= 1'b0;
                        state     <= FS_RUN;
                    end else if (!stall) begin
                        if_instr <= imem_rdata;
                        if_pc    <= req_pc;
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= FS_BOOT;
                    req_valid <= 1'b0;
                    if_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    // fetch_inc mirrors exactly the RUN advance that writes if_valid<=1.
    assign fetch_inc = (state == FS_RUN) && !redirect && !stall && req_valid;
    assign stall_inc = (state == FS_RUN) && stall && !redirect;

    fetch_sat_counter #(.W(32)) u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fetch_inc),
        .cnt (fetch_cnt)
    );

    fetch_sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural registered-address
//   memory feeds the DUT; expected (pc, instr) pairs are queued as stimulus is
//   applied and popped whenever IF/ID presents a valid entry.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [15:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word a = 0x1000_0000 + a + 1, word 6 = halt when enabled.
    logic halt_en;

    function automatic logic [31:0] word_at(input logic [15:0] a, input logic hen);
        if (hen && a == 16'd6) return 32'hF000_0000;
        return 32'h1000_0000 + {16'h0, a} + 32'd1;
    endfunction

    always @(posedge clk) imem_rdata <= word_at(imem_addr, halt_en);

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = word_at(pc, halt_en);
        sb_q.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge; when 'sample' is
    // set, every valid IF/ID entry must match the head of the scoreboard.
    task automatic tick(input bit sample);
        exp_t e;
        @(posedge clk);
        #1;
        if (sample && if_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_valid_pc", {16'h0, if_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_pc", {16'h0, if_pc}, {16'h0, e.pc});
                check_val("sb_instr", if_instr, e.instr);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        halt_en     = 1'b0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;

        tick(0);
        tick(0);
        check_val("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check_val("rst_if_pc", {16'h0, if_pc}, 32'h0);
        check_val("rst_if_instr", if_instr, 32'h0);
        check_val("rst_halted", {31'h0, halted}, 32'h0);
        check_val("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

        // Boot: BOOT cycle ignores stall/redirect.
        rst         = 1'b0;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0123;
        #1;
        check_val("boot_imem_addr", {16'h0, imem_addr}, 32'h0);
        push_exp(16'd0); push_exp(16'd1); push_exp(16'd2);
        tick(1);
        stall    = 1'b0;
        redirect = 1'b0;
        check_val("boot_if_valid", {31'h0, if_valid}, 32'h0);
        tick(1);
        check_val("first_valid", {31'h0, if_valid}, 32'h1);
        tick(1);
        tick(1);
        check_val("pc2_shown", {16'h0, if_pc}, 32'd2);

        // Stall for 3 cycles while if_pc = 2.
        stall = 1'b1;
        #1;
        check_val("stall_imem_addr", {16'h0, imem_addr}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check_val("stall_if_pc", {16'h0, if_pc}, 32'd2);
            check_val("stall_if_instr", if_instr, 32'h1000_0003);
            check_val("stall_if_valid", {31'h0, if_valid}, 32'h1);
            check_val("stall_hold_addr", {16'h0, imem_addr}, 32'd3);
        end
        stall = 1'b0;
        push_exp(16'd3); push_exp(16'd4); push_exp(16'd5);
        tick(1); tick(1); tick(1);
        check_val("pc5_shown", {16'h0, if_pc}, 32'd5);

        // Redirect to 0x40, then again with a concurrent stall.
        for (int r = 0; r < 2; r++) begin
            redirect    = 1'b1;
            redirect_pc = 16'h0040;
            stall       = (r == 1);
            #1;
            check_val("redir_imem_addr", {16'h0, imem_addr}, 32'h40);
            push_exp(16'h0040); push_exp(16'h0041);
            tick(1);
            redirect = 1'b0;
            stall    = 1'b0;
            check_val("redir_bubble", {31'h0, if_valid}, 32'h0);
            tick(1);
            tick(1);
            check_val("redir_pc41", {16'h0, if_pc}, 32'h41);
        end

        // Halt at word 6.
        halt_en     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'd4;
        push_exp(16'd4); push_exp(16'd5); push_exp(16'd6);
        tick(1);
        redirect = 1'b0;
        tick(1); tick(1); tick(1);
        check_val("halt_if_pc", {16'h0, if_pc}, 32'd6);
        check_val("halt_if_valid", {31'h0, if_valid}, 32'h1);
        check_val("halt_halted", {31'h0, halted}, 32'h1);
        check_val("halt_imem_addr", {16'h0, imem_addr}, 32'd7);
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check_val("halt_no_valid", {31'h0, if_valid}, 32'h0);
            check_val("halt_stays", {31'h0, halted}, 32'h1);
            check_val("halt_addr_frozen", {16'h0, imem_addr}, 32'd7);
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        push_exp(16'h0010); push_exp(16'h0011);
        tick(1);
        redirect = 1'b0;
        check_val("unhalt_halted", {31'h0, halted}, 32'h0);
        check_val("unhalt_bubble", {31'h0, if_valid}, 32'h0);
        tick(1);
        tick(1);

        // PC wrap.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        push_exp(16'hFFFE); push_exp(16'hFFFF); push_exp(16'h0000);
        tick(1);
        redirect = 1'b0;
        tick(1); tick(1); tick(1);
        check_val("wrap_if_pc", {16'h0, if_pc}, 32'h0);

        // Reset mid-stream.
        rst = 1'b1;
        #1;
        check_val("midrst_imem_addr", {16'h0, imem_addr}, 32'h0);
        tick(0);
        check_val("midrst_if_valid", {31'h0, if_valid}, 32'h0);
        check_val("midrst_if_pc", {16'h0, if_pc}, 32'h0);
        check_val("midrst_if_instr", if_instr, 32'h0);
        check_val("midrst_halted", {31'h0, halted}, 32'h0);
        check_val("sb_drained", sb_q.size(), 32'd0);
        sb_q.delete();

        // Restart: 10 fetches with 4 stall cycles in the middle.
        halt_en = 1'b0;
        rst     = 1'b0;
        for (int a = 0; a < 10; a++) push_exp(16'(a));
        tick(1);
        check_val("reboot_if_valid", {31'h0, if_valid}, 32'h0);
        for (int i = 0; i < 6; i++) tick(1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0);
            check_val("rb_stall_pc", {16'h0, if_pc}, 32'd5);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) tick(1);
        check_val("rb_last_pc", {16'h0, if_pc}, 32'd9);
        check_val("rb_sb_drained", sb_q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_val("fetch_cnt", fetch_cnt, 32'd10);
        check_val("stall_cnt", stall_cnt, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
